// File: rtl/ycbcr_to_rgb_axis.sv
// Byte-serial YCrCb -> RGB AXI-Stream decoder: input assembler, multiply stage P, add/limit stage O, RGB serializer.
// Define YCC_SATURATE_EN to clamp results to 0..255; otherwise results wrap to their low 8 bits.
module ycbcr_to_rgb_axis #(
  parameter int FRAME_PIXELS = 256060,
  parameter int CNT_W        = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic [7:0] s_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tlast
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  function automatic logic [7:0] limitPix(input logic signed [10:0] v);
    logic [7:0] res;
`ifdef YCC_SATURATE_EN
    if (v < 11'sd0) begin
      res = 8'd0;
    end else if (v > 11'sd255) begin
      res = 8'd255;
    end else begin
      res = v[7:0];
    end
`else
    res = v[7:0];
`endif
    return res;
  endfunction

  function automatic logic signed [18:0] sext19(input logic signed [17:0] v);
    return {v[17], v};
  endfunction

  logic [1:0]              inPhase_r;
  logic [7:0]              yHold_r;
  logic [7:0]              crHold_r;
  logic                    pValid_r;
  logic [7:0]              pY_r;
  logic signed [17:0]      pCrR_r, pCrG_r, pCbG_r, pCbB_r;
  logic [1:0]              outPhase_r;
  logic [7:0]              oG_r, oB_r;
  logic                    mValid_r, mLast_r;
  logic [7:0]              mData_r;
  logic [CNT_W-1:0]        pixCnt_r;

  logic                    sReady_s, sHs_s, mHs_s, pToO_s;
  logic signed [17:0]      crD_s, cbD_s;
  logic signed [18:0]      rSum_s, gSum_s, bSum_s;
  logic signed [10:0]      yExt_s, rRes_s, gRes_s, bRes_s;

  // Handshakes and the P->O advance; P may reload in the same cycle it advances.
  always_comb begin
    pToO_s   = pValid_r & (~mValid_r | ((outPhase_r == 2'd2) & m_axis_tready));
    sReady_s = ~((inPhase_r == 2'd2) & pValid_r & ~pToO_s);
    sHs_s    = s_axis_tvalid & sReady_s;
    mHs_s    = mValid_r & m_axis_tready;
  end

  // Chroma offsets; Cb is taken straight from the bus on the launching beat.
  always_comb begin
    crD_s = $signed({10'd0, crHold_r}) - 18'sd128;
    cbD_s = $signed({10'd0, s_axis_tdata}) - 18'sd128;
  end

  // Stage O arithmetic: round with +128, floor-shift by 8, add to luma.
  always_comb begin
    yExt_s = $signed({3'd0, pY_r});
    rSum_s = sext19(pCrR_r) + 19'sd128;
    gSum_s = sext19(pCrG_r) + sext19(pCbG_r) + 19'sd128;
    bSum_s = sext19(pCbB_r) + 19'sd128;
    rRes_s = yExt_s + $signed(11'(rSum_s >>> 8));
    gRes_s = yExt_s - $signed(11'(gSum_s >>> 8));
    bRes_s = yExt_s + $signed(11'(bSum_s >>> 8));
  end

  // Input assembler: Y and Cr are held here, Cb launches the triplet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inPhase_r <= 2'd0;
      yHold_r   <= 8'd0;
      crHold_r  <= 8'd0;
    end else if (sHs_s) begin
      case (inPhase_r)
        2'd0: begin
          yHold_r   <= s_axis_tdata;
          inPhase_r <= 2'd1;
        end
        2'd1: begin
          crHold_r  <= s_axis_tdata;
          inPhase_r <= 2'd2;
        end
        2'd2: inPhase_r <= 2'd0;
        default: inPhase_r <= 2'd0;
      endcase
    end
  end

  // Stage P: products and luma copy, so the assembler is free to take the next Y/Cr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pValid_r <= 1'b0;
      pY_r     <= 8'd0;
      pCrR_r   <= 18'sd0;
      pCrG_r   <= 18'sd0;
      pCbG_r   <= 18'sd0;
      pCbB_r   <= 18'sd0;
    end else if (sHs_s && (inPhase_r == 2'd2)) begin
      pValid_r <= 1'b1;
      pY_r     <= yHold_r;
      pCrR_r   <= crD_s * 18'sd359;
      pCrG_r   <= crD_s * 18'sd183;
      pCbG_r   <= cbD_s * 18'sd88;
      pCbB_r   <= cbD_s * 18'sd454;
    end else if (pToO_s) begin
      pValid_r <= 1'b0;
    end
  end

  // Stage O and serializer: R goes straight to the output register, G/B wait in the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outPhase_r <= 2'd0;
      oG_r       <= 8'd0;
      oB_r       <= 8'd0;
      mValid_r   <= 1'b0;
      mData_r    <= 8'd0;
      mLast_r    <= 1'b0;
    end else if (pToO_s) begin
      outPhase_r <= 2'd0;
      oG_r       <= limitPix(gRes_s);
      oB_r       <= limitPix(bRes_s);
      mValid_r   <= 1'b1;
      mData_r    <= limitPix(rRes_s);
      mLast_r    <= 1'b0;
    end else if (mHs_s) begin
      case (outPhase_r)
        2'd0: begin
          mData_r    <= oG_r;
          outPhase_r <= 2'd1;
        end
        2'd1: begin
          mData_r    <= oB_r;
          mLast_r    <= (pixCnt_r == LAST_PIX);
          outPhase_r <= 2'd2;
        end
        2'd2: begin
          mValid_r   <= 1'b0;
          mLast_r    <= 1'b0;
          outPhase_r <= 2'd0;
        end
        default: begin
          mValid_r   <= 1'b0;
          mLast_r    <= 1'b0;
          outPhase_r <= 2'd0;
        end
      endcase
    end
  end

  // Frame pixel counter, stepped on each B handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixCnt_r <= '0;
    end else if (mHs_s && (outPhase_r == 2'd2)) begin
      pixCnt_r <= (pixCnt_r == LAST_PIX) ? '0 : pixCnt_r + 1'b1;
    end
  end

  assign s_axis_tready = sReady_s;
  assign m_axis_tvalid = mValid_r;
  assign m_axis_tdata  = mData_r;
  assign m_axis_tlast  = mLast_r;

endmodule

// File: tb/tb_ycbcr_to_rgb_axis.sv
// Self-checking bench for ycbcr_to_rgb_axis with a 4-pixel frame and an arithmetic reference model.
module tb_ycbcr_to_rgb_axis;

  localparam int FP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata = 8'd0;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tlast;

  int passCnt = 0;
  int totCnt  = 0;
  int cyc     = 0;
  int inBytes = 0;
  int outBeats = 0;
  int stabErr = 0;
  int rdyLow = 0;
  int rdyLowBad = 0;
  int modelCnt = 0;
  logic       stallPrev = 1'b0;
  logic [9:0] heldOut = 10'd0;

  logic [8:0] expQ[$];
  logic [7:0] gotD[$];
  logic       gotL[$];
  int         gotC[$];

  ycbcr_to_rgb_axis #(.FRAME_PIXELS(FP), .CNT_W(18)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records output beats, output stability under stall, and when input ready drops.
  always @(negedge clk) begin
    if (rst) begin
      inBytes   <= 0;
      outBeats  <= 0;
      stallPrev <= 1'b0;
    end else begin
      if (stallPrev && ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== heldOut)) stabErr <= stabErr + 1;
      stallPrev <= m_axis_tvalid && !m_axis_tready;
      heldOut   <= {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
      if (!s_axis_tready) begin
        rdyLow <= rdyLow + 1;
        if ((inBytes % 3 != 2) || ((inBytes / 3) - (outBeats / 3) != 2)) rdyLowBad <= rdyLowBad + 1;
      end
      if (s_axis_tvalid && s_axis_tready) inBytes <= inBytes + 1;
      if (m_axis_tvalid && m_axis_tready) begin
        gotD.push_back(m_axis_tdata);
        gotL.push_back(m_axis_tlast);
        gotC.push_back(cyc);
        outBeats <= outBeats + 1;
      end
    end
  end

  function automatic int floorDiv256(int n);
    int q;
    q = n / 256;
    if (n < 0 && q * 256 != n) q = q - 1;
    return q;
  endfunction

  function automatic logic [7:0] limitRef(int v);
`ifdef YCC_SATURATE_EN
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
`endif
    return v[7:0];
  endfunction

  task automatic pushPixel(input int y, input int cr, input int cb);
    int r, g, b;
    r = y + floorDiv256(359 * (cr - 128) + 128);
    g = y - floorDiv256(183 * (cr - 128) + 88 * (cb - 128) + 128);
    b = y + floorDiv256(454 * (cb - 128) + 128);
    expQ.push_back({1'b0, limitRef(r)});
    expQ.push_back({1'b0, limitRef(g)});
    expQ.push_back({(modelCnt == FP - 1), limitRef(b)});
    modelCnt = (modelCnt + 1) % FP;
  endtask

  task automatic sendByte(input logic [7:0] d);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_axis_tvalid = 1'b0;
    if (!acc) begin
      totCnt++;
      $display("FAIL send_timeout: byte %0d not accepted within %0d cycles", d, n);
    end
  endtask

  task automatic sendPixel(input int y, input int cr, input int cb);
    pushPixel(y, cr, cb);
    sendByte(8'(y));
    sendByte(8'(cr));
    sendByte(8'(cb));
  endtask

  task automatic waitBeats(input int n);
    int k;
    k = 0;
    while (gotD.size() < n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    totCnt += 4;
    if (s_axis_tready !== 1'b1) $display("FAIL reset_s_tready: got %0b want 1", s_axis_tready); else passCnt++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %0b want 0", m_axis_tvalid); else passCnt++;
    if (m_axis_tdata !== 8'd0) $display("FAIL reset_m_tdata: got %0d want 0", m_axis_tdata); else passCnt++;
    if (m_axis_tlast !== 1'b0) $display("FAIL reset_m_tlast: got %0b want 0", m_axis_tlast); else passCnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    modelCnt = 0;
  endtask

  task automatic test_latency;
    int base;
    base = gotD.size();
    expQ.delete();
    sendPixel(128, 128, 128);
    @(negedge clk);
    totCnt++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL latency_early: tvalid %0b one cycle after Cb, want 0", m_axis_tvalid); else passCnt++;
    @(negedge clk);
    totCnt++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'd128)
      $display("FAIL latency_r_beat: tvalid %0b data %0d, want 1 and 128", m_axis_tvalid, m_axis_tdata);
    else passCnt++;
    waitBeats(base + 3);
    for (int i = 0; i < 3; i++) begin
      totCnt++;
      if (gotD[base + i] !== 8'd128) $display("FAIL grey_beat%0d: got %0d want 128", i, gotD[base + i]); else passCnt++;
    end
  endtask

  task automatic test_corners;
    int base;
    logic [7:0] want [6];
`ifdef YCC_SATURATE_EN
    want = '{8'd255, 8'd164, 8'd255, 8'd0, 8'd135, 8'd0};
`else
    want = '{8'd177, 8'd164, 8'd255, 8'd77, 8'd135, 8'd29};
`endif
    base = gotD.size();
    expQ.delete();
    sendPixel(255, 255, 128);
    sendPixel(0, 0, 0);
    waitBeats(base + 6);
    totCnt++;
    if (gotD.size() - base != 6) $display("FAIL corner_count: got %0d beats want 6", gotD.size() - base); else passCnt++;
    for (int i = 0; i < 6; i++) begin
      totCnt++;
      if (base + i >= gotD.size() || gotD[base + i] !== want[i])
        $display("FAIL corner_beat%0d: got %0d want %0d", i, (base + i < gotD.size()) ? gotD[base + i] : 8'hxx, want[i]);
      else passCnt++;
    end
  endtask

  task automatic test_stream;
    int base, lowBefore, gapErr;
    base = gotD.size();
    lowBefore = rdyLow;
    expQ.delete();
    for (int p = 0; p < 64; p++) sendPixel($urandom_range(255), $urandom_range(255), $urandom_range(255));
    waitBeats(base + 192);
    totCnt++;
    if (gotD.size() - base != 192) $display("FAIL stream_count: got %0d beats want 192", gotD.size() - base); else passCnt++;
    for (int i = 0; i < expQ.size(); i++) begin
      totCnt++;
      if (base + i >= gotD.size() || {gotL[base + i], gotD[base + i]} !== expQ[i])
        $display("FAIL stream_beat%0d: got %0h want %0h", i, (base + i < gotD.size()) ? {gotL[base + i], gotD[base + i]} : 9'hxxx, expQ[i]);
      else passCnt++;
    end
    gapErr = 0;
    for (int i = base; i + 1 < gotC.size(); i++) if (gotC[i + 1] != gotC[i] + 1) gapErr++;
    totCnt++;
    if (gapErr != 0) $display("FAIL stream_gaps: %0d non-consecutive output beats, want 0", gapErr); else passCnt++;
    totCnt++;
    if (rdyLow != lowBefore) $display("FAIL stream_s_tready: low %0d cycles, want 0", rdyLow - lowBefore); else passCnt++;
  endtask

  task automatic test_backpressure;
    int base, lowBefore;
    base = gotD.size();
    lowBefore = rdyLow;
    expQ.delete();
    fork
      begin
        for (int p = 0; p < 12; p++) sendPixel($urandom_range(255), $urandom_range(255), $urandom_range(255));
      end
      begin
        repeat (10) @(posedge clk);
        #1 m_axis_tready = 1'b0;
        repeat (20) @(posedge clk);
        #1 m_axis_tready = 1'b1;
      end
    join
    waitBeats(base + 36);
    totCnt++;
    if (gotD.size() - base != 36) $display("FAIL bp_count: got %0d beats want 36", gotD.size() - base); else passCnt++;
    for (int i = 0; i < expQ.size(); i++) begin
      totCnt++;
      if (base + i >= gotD.size() || {gotL[base + i], gotD[base + i]} !== expQ[i])
        $display("FAIL bp_beat%0d: got %0h want %0h", i, (base + i < gotD.size()) ? {gotL[base + i], gotD[base + i]} : 9'hxxx, expQ[i]);
      else passCnt++;
    end
    totCnt++;
    if (stabErr != 0) $display("FAIL bp_stable: %0d output changes while stalled, want 0", stabErr); else passCnt++;
    totCnt++;
    if (rdyLow == lowBefore) $display("FAIL bp_s_tready_drop: low %0d cycles, want >0", rdyLow - lowBefore); else passCnt++;
    totCnt++;
    if (rdyLowBad != 0) $display("FAIL bp_s_tready_when: %0d low cycles outside phase 2 with P and O full, want 0", rdyLowBad); else passCnt++;
  endtask

  task automatic test_tlast;
    int base;
    test_reset();
    base = gotD.size();
    expQ.delete();
    for (int p = 0; p < 9; p++) sendPixel($urandom_range(255), $urandom_range(255), $urandom_range(255));
    waitBeats(base + 27);
    totCnt++;
    if (gotD.size() - base != 27) $display("FAIL tlast_count: got %0d beats want 27", gotD.size() - base); else passCnt++;
    for (int i = 0; i < 27; i++) begin
      totCnt++;
      if (base + i >= gotL.size() || gotL[base + i] !== (i % 12 == 11))
        $display("FAIL tlast_beat%0d: got %0b want %0b", i, (base + i < gotL.size()) ? gotL[base + i] : 1'bx, (i % 12 == 11));
      else passCnt++;
    end
  endtask

  task automatic test_reset_mid;
    int base;
    sendByte(8'd50);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'd200;
    #2 rst = 1'b1;
    @(negedge clk);
    totCnt += 4;
    if (s_axis_tready !== 1'b1) $display("FAIL midrst_s_tready: got %0b want 1", s_axis_tready); else passCnt++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL midrst_m_tvalid: got %0b want 0", m_axis_tvalid); else passCnt++;
    if (m_axis_tdata !== 8'd0) $display("FAIL midrst_m_tdata: got %0d want 0", m_axis_tdata); else passCnt++;
    if (m_axis_tlast !== 1'b0) $display("FAIL midrst_m_tlast: got %0b want 0", m_axis_tlast); else passCnt++;
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    modelCnt = 0;
    base = gotD.size();
    expQ.delete();
    sendPixel(90, 60, 240);
    waitBeats(base + 3);
    totCnt++;
    if (gotD.size() - base != 3) $display("FAIL midrst_count: got %0d beats want 3", gotD.size() - base); else passCnt++;
    for (int i = 0; i < expQ.size(); i++) begin
      totCnt++;
      if (base + i >= gotD.size() || {gotL[base + i], gotD[base + i]} !== expQ[i])
        $display("FAIL midrst_beat%0d: got %0h want %0h", i, (base + i < gotD.size()) ? {gotL[base + i], gotD[base + i]} : 9'hxxx, expQ[i]);
      else passCnt++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_stream();
    test_backpressure();
    test_tlast();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totCnt);
    $finish;
  end

endmodule
